fb_block_reader: RTL and testbench

//  Frame-buffer read master directly downstream of the 4xSPRAM byte frame store. After the camera has

---
 rtl/fb_pkg.sv | 24 ++
 rtl/fb_rd_fifo.sv | 46 ++++
 rtl/fb_block_reader.sv | 169 ++++++++++++++++
 tb/tb_fb_block_reader.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/fb_pkg.sv
// Shared constants and types for the frame-buffer block reader.
//   FB_ADDR_W : store byte address width
//   FB_BLK    : block edge length in pixels
//   fb_state_t: read FSM states
//   fb_pix_t  : FIFO entry, pixel byte plus the flags that travel with it
package fb_pkg;
  localparam int FB_ADDR_W = 17;
  localparam int FB_BLK    = 8;
  localparam int FB_PIX_W  = 11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_HOLD  = 2'd2,
    ST_DRAIN = 2'd3
  } fb_state_t;

  typedef struct packed {
    logic       flast;
    logic       blast;
    logic       bfirst;
    logic [7:0] data;
  } fb_pix_t;
endpackage

// File: rtl/fb_rd_fifo.sv
// 2-deep output FIFO between the store read path and the pixel stream.
//   i_clk, i_rst_n : clock, async active-low reset
//   i_push, i_din  : write one entry (accepted when not full or popping)
//   i_pop          : remove head entry (ignored when empty)
//   o_dout         : head entry
//   o_cnt          : number of valid entries (0..2)
module fb_rd_fifo
  import fb_pkg::*;
(
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_push,
  input  logic [FB_PIX_W-1:0] i_din,
  input  logic                i_pop,
  output logic [FB_PIX_W-1:0] o_dout,
  output logic [1:0]          o_cnt
);
  logic [FB_PIX_W-1:0] r_mem [2];
  logic                r_wp, r_rp;
  logic [1:0]          r_cnt;
  logic                w_do_pop, w_do_push;

  assign w_do_pop  = i_pop && (r_cnt != 2'd0);
  // push into a full FIFO is fine when the head leaves in the same cycle
  assign w_do_push = i_push && ((r_cnt != 2'd2) || w_do_pop);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_mem[0] <= '0;
      r_mem[1] <= '0;
      r_wp     <= 1'b0;
      r_rp     <= 1'b0;
      r_cnt    <= 2'd0;
    end else begin
      if (w_do_push) begin
        r_mem[r_wp] <= i_din;
        r_wp        <= ~r_wp;
      end
      if (w_do_pop) r_rp <= ~r_rp;
      r_cnt <= r_cnt + {1'b0, w_do_push} - {1'b0, w_do_pop};
    end
  end

  assign o_dout = r_mem[r_rp];
  assign o_cnt  = r_cnt;
endmodule

// File: rtl/fb_block_reader.sv
// Frame-buffer read master: walks a raster frame in 8x8 blocks, reads the
// byte store (2-cycle address hold, data sampled in the third cycle) and
// streams pixels to the encoder over valid/ready.
//   i_rd_clk, i_reset_n : clock, async active-low reset
//   i_start             : begin one frame (ignored while busy)
//   o_busy, o_done      : frame in progress / 1-cycle completion pulse
//   i_wr_busy           : store write active, voids the read in flight
//   o_rd_addr, i_rd_data: store read port
//   o_pix_*, i_pix_ready: pixel stream with block/frame flags
module fb_block_reader
  import fb_pkg::*;
#(
  parameter int IMG_W     = 320,
  parameter int IMG_H     = 240,
  parameter int BASE_ADDR = 0
) (
  input  logic        i_rd_clk,
  input  logic        i_reset_n,
  input  logic        i_start,
  output logic        o_busy,
  output logic        o_done,
  input  logic        i_wr_busy,
  output logic [16:0] o_rd_addr,
  input  logic [7:0]  i_rd_data,
  output logic [7:0]  o_pix_data,
  output logic        o_pix_valid,
  input  logic        i_pix_ready,
  output logic        o_blk_first,
  output logic        o_blk_last,
  output logic        o_frame_last
);
  localparam logic [FB_ADDR_W-1:0] W_ROW    = FB_ADDR_W'(IMG_W);
  localparam logic [FB_ADDR_W-1:0] W_BAND   = FB_ADDR_W'(IMG_W * FB_BLK);
  localparam logic [FB_ADDR_W-1:0] BLK_STEP = FB_ADDR_W'(FB_BLK);
  localparam logic [FB_ADDR_W-1:0] A_BASE   = FB_ADDR_W'(BASE_ADDR);
  localparam logic [FB_ADDR_W-1:0] BX_LAST  = FB_ADDR_W'(IMG_W / FB_BLK - 1);
  localparam logic [FB_ADDR_W-1:0] BY_LAST  = FB_ADDR_W'(IMG_H / FB_BLK - 1);
  localparam logic [2:0]           P_LAST   = 3'(FB_BLK - 1);

  fb_state_t            r_state;
  logic [FB_ADDR_W-1:0] r_rd_addr, r_row_base, r_blk_base, r_band_base;
  logic [FB_ADDR_W-1:0] r_bx, r_by;
  logic [2:0]           r_col, r_row;
  logic                 r_coll, r_samp, r_busy, r_done;
  logic [2:0]           r_sflags;

  logic [FB_ADDR_W-1:0] w_nxt_row, w_nxt_blk, w_nxt_band;
  logic                 w_first, w_last, w_end, w_proceed, w_pop;
  logic [1:0]           w_cnt;
  fb_pix_t              w_head;

  assign w_nxt_row  = r_row_base + W_ROW;
  assign w_nxt_blk  = r_blk_base + BLK_STEP;
  assign w_nxt_band = r_band_base + W_BAND;

  assign w_first = (r_row == 3'd0) && (r_col == 3'd0);
  assign w_last  = (r_row == P_LAST) && (r_col == P_LAST);
  assign w_end   = w_last && (r_bx == BX_LAST) && (r_by == BY_LAST);

  // a new read may only start if the FIFO can take it on top of the one
  // whose data is being sampled this cycle
  assign w_proceed = (2'd2 - w_cnt) > {1'b0, r_samp};
  assign w_pop     = o_pix_valid && i_pix_ready;

  fb_rd_fifo u_fifo (
    .i_clk   (i_rd_clk),
    .i_rst_n (i_reset_n),
    .i_push  (r_samp),
    .i_din   ({r_sflags, i_rd_data}),
    .i_pop   (w_pop),
    .o_dout  (w_head),
    .o_cnt   (w_cnt)
  );

  always_ff @(posedge i_rd_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state     <= ST_IDLE;
      r_rd_addr   <= '0;
      r_row_base  <= '0;
      r_blk_base  <= '0;
      r_band_base <= '0;
      r_bx        <= '0;
      r_by        <= '0;
      r_col       <= 3'd0;
      r_row       <= 3'd0;
      r_coll      <= 1'b0;
      r_samp      <= 1'b0;
      r_sflags    <= 3'd0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_samp <= 1'b0;
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: if (i_start) begin
          r_state     <= ST_ISSUE;
          r_busy      <= 1'b1;
          r_rd_addr   <= A_BASE;
          r_row_base  <= A_BASE;
          r_blk_base  <= A_BASE;
          r_band_base <= A_BASE;
          r_bx        <= '0;
          r_by        <= '0;
          r_col       <= 3'd0;
          r_row       <= 3'd0;
        end
        ST_ISSUE: if (w_proceed) begin
          r_coll  <= i_wr_busy;
          r_state <= ST_HOLD;
        end
        ST_HOLD: begin
          if (r_coll || i_wr_busy) begin
            // store returned nothing useful: present the same address again
            r_state <= ST_ISSUE;
          end else begin
            r_samp   <= 1'b1;
            r_sflags <= {w_end, w_last, w_first};
            if (w_end) begin
              r_state <= ST_DRAIN;
            end else begin
              r_state <= ST_ISSUE;
              if (r_col != P_LAST) begin
                r_col     <= r_col + 3'd1;
                r_rd_addr <= r_rd_addr + 17'd1;
              end else begin
                r_col <= 3'd0;
                if (r_row != P_LAST) begin
                  r_row      <= r_row + 3'd1;
                  r_row_base <= w_nxt_row;
                  r_rd_addr  <= w_nxt_row;
                end else begin
                  r_row <= 3'd0;
                  if (r_bx != BX_LAST) begin
                    r_bx       <= r_bx + 17'd1;
                    r_blk_base <= w_nxt_blk;
                    r_row_base <= w_nxt_blk;
                    r_rd_addr  <= w_nxt_blk;
                  end else begin
                    r_bx        <= '0;
                    r_by        <= r_by + 17'd1;
                    r_band_base <= w_nxt_band;
                    r_blk_base  <= w_nxt_band;
                    r_row_base  <= w_nxt_band;
                    r_rd_addr   <= w_nxt_band;
                  end
                end
              end
            end
          end
        end
        ST_DRAIN: if (w_pop && w_head.flast) begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b1;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign o_busy       = r_busy;
  assign o_done       = r_done;
  assign o_rd_addr    = r_rd_addr;
  assign o_pix_valid  = (w_cnt != 2'd0);
  assign o_pix_data   = w_head.data;
  assign o_blk_first  = o_pix_valid && w_head.bfirst;
  assign o_blk_last   = o_pix_valid && w_head.blast;
  assign o_frame_last = o_pix_valid && w_head.flast;
endmodule

// File: tb/tb_fb_block_reader.sv
module tb_fb_block_reader;
  localparam int NU = 2;
  localparam int UW[NU] = '{16, 80};
  localparam int UH[NU] = '{8, 48};
  localparam int UB[NU] = '{0, 1000};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_n;
  logic        start[NU], wr_busy[NU], pix_ready[NU];
  logic        busy[NU], done[NU], pix_valid[NU];
  logic        blk_first[NU], blk_last[NU], frame_last[NU];
  logic [16:0] rd_addr[NU];
  logic [7:0]  rd_data[NU], pix_data[NU];
  logic [7:0]  mem [0:131071];

  int n_pass = 0, n_chk = 0, n_fail = 0;
  int pix_idx[NU], addr_idx[NU], n_bfirst[NU], n_blast[NU], n_flast[NU], n_done[NU];
  int last_addr[NU];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // raster address of the k-th pixel in block order
  function automatic int exp_addr(input int g, input int k);
    int bpr, blk, w;
    bpr = UW[g] / 8;
    blk = k / 64;
    w   = k % 64;
    return UB[g] + ((blk / bpr) * 8 + w / 8) * UW[g] + (blk % bpr) * 8 + w % 8;
  endfunction

  for (genvar g = 0; g < NU; g++) begin : u
    fb_block_reader #(.IMG_W(UW[g]), .IMG_H(UH[g]), .BASE_ADDR(UB[g])) dut (
      .i_rd_clk     (clk),
      .i_reset_n    (reset_n),
      .i_start      (start[g]),
      .o_busy       (busy[g]),
      .o_done       (done[g]),
      .i_wr_busy    (wr_busy[g]),
      .o_rd_addr    (rd_addr[g]),
      .i_rd_data    (rd_data[g]),
      .o_pix_data   (pix_data[g]),
      .o_pix_valid  (pix_valid[g]),
      .i_pix_ready  (pix_ready[g]),
      .o_blk_first  (blk_first[g]),
      .o_blk_last   (blk_last[g]),
      .o_frame_last (frame_last[g])
    );

    // store model: address must be held two cycles, any write in that window voids the read
    logic [16:0] p_addr;
    logic        p_coll;
    always @(posedge clk) begin
      p_addr     <= rd_addr[g];
      p_coll     <= wr_busy[g];
      rd_data[g] <= (p_coll || wr_busy[g] || p_addr != rd_addr[g]) ? 8'h00 : mem[p_addr];
    end

    // scoreboard on the pixel stream and the issued address sequence
    always @(negedge clk) begin
      int k, total;
      total = UW[g] * UH[g];
      if (!reset_n || (start[g] && !busy[g])) begin
        pix_idx[g] = 0; addr_idx[g] = 0; last_addr[g] = -1;
        n_bfirst[g] = 0; n_blast[g] = 0; n_flast[g] = 0; n_done[g] = 0;
      end else begin
        if (pix_valid[g] && pix_ready[g]) begin
          k = pix_idx[g];
          if (k >= total) check("pix_overrun", k, total - 1);
          else begin
            check("pix_data", pix_data[g], mem[exp_addr(g, k)]);
            check("blk_first", blk_first[g], (k % 64) == 0);
            check("blk_last", blk_last[g], (k % 64) == 63);
            check("frame_last", frame_last[g], k == total - 1);
          end
          pix_idx[g]++;
          n_bfirst[g] += blk_first[g];
          n_blast[g]  += blk_last[g];
          n_flast[g]  += frame_last[g];
        end
        if (done[g]) n_done[g]++;
        if (busy[g] && int'(rd_addr[g]) != last_addr[g]) begin
          if (addr_idx[g] >= total) check("addr_overrun", addr_idx[g], total - 1);
          else check("rd_addr_seq", rd_addr[g], exp_addr(g, addr_idx[g]));
          addr_idx[g]++;
          last_addr[g] = int'(rd_addr[g]);
        end
      end
    end
  end

  task automatic step(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_start(input int g);
    start[g] = 1'b1;
    step();
    start[g] = 1'b0;
  endtask

  task automatic wait_pix(input int g, input int n);
    int c = 0;
    while (pix_idx[g] < n && c < 2000) begin step(); c++; end
    check("wait_pix_timeout", pix_idx[g] >= n, 1);
  endtask

  task automatic wait_done(input int g, input int limit);
    int c = 0;
    while (!done[g] && c < limit) begin step(); c++; end
    check("done_timeout", done[g], 1);
    step(2);
  endtask

  task automatic frame_end(input int g);
    int total = UW[g] * UH[g];
    check("frame_pixels", pix_idx[g], total);
    check("frame_bfirst", n_bfirst[g], total / 64);
    check("frame_blast", n_blast[g], total / 64);
    check("frame_flast", n_flast[g], 1);
    check("done_pulses", n_done[g], 1);
    check("busy_after_done", busy[g], 0);
  endtask

  initial begin
    for (int i = 0; i < 131072; i++) mem[i] = 8'($urandom_range(1, 255));
    reset_n = 1'b0;
    for (int g = 0; g < NU; g++) begin
      start[g] = 1'b0; wr_busy[g] = 1'b0; pix_ready[g] = 1'b0;
    end
    step(3);
    // reset state
    for (int g = 0; g < NU; g++) begin
      check("rst_busy", busy[g], 0);
      check("rst_done", done[g], 0);
      check("rst_rd_addr", rd_addr[g], 0);
      check("rst_valid", pix_valid[g], 0);
      check("rst_pix_data", pix_data[g], 0);
      check("rst_flags", {blk_first[g], blk_last[g], frame_last[g]}, 0);
    end
    reset_n = 1'b1;
    step();

    // block order, continuous ready
    pix_ready[0] = 1'b1;
    pulse_start(0);
    check("start_busy", busy[0], 1);
    check("start_addr", rd_addr[0], UB[0]);
    wait_done(0, 2000);
    frame_end(0);

    // backpressure mid-block
    pulse_start(0);
    wait_pix(0, 20);
    pix_ready[0] = 1'b0;
    step(20);
    check("bp_valid", pix_valid[0], 1);
    check("bp_head", pix_data[0], mem[exp_addr(0, 20)]);
    check("bp_addr_frozen", rd_addr[0], exp_addr(0, 22));
    check("bp_no_pop", pix_idx[0], 20);
    pix_ready[0] = 1'b1;
    wait_done(0, 2000);
    frame_end(0);

    // write collision during the hold cycle of address 37
    pulse_start(0);
    begin
      int c = 0;
      while (rd_addr[0] != 17'd37 && c < 500) begin step(); c++; end
    end
    check("coll_reach37", rd_addr[0], 37);
    step();
    wr_busy[0] = 1'b1;
    step();
    wr_busy[0] = 1'b0;
    check("coll_reissue", rd_addr[0], 37);
    wait_done(0, 2000);
    frame_end(0);

    // ignored start while busy, then reset mid-frame
    pulse_start(0);
    wait_pix(0, 50);
    pulse_start(0);
    wait_pix(0, 100);
    reset_n = 1'b0;
    #1;
    check("midrst_busy", busy[0], 0);
    check("midrst_valid", pix_valid[0], 0);
    check("midrst_addr", rd_addr[0], 0);
    step(2);
    reset_n = 1'b1;
    step();
    pulse_start(0);
    check("restart_busy", busy[0], 1);
    check("restart_addr", rd_addr[0], UB[0]);
    wait_done(0, 2000);
    frame_end(0);

    // larger frame with random backpressure and write traffic
    pulse_start(1);
    begin
      int c = 0;
      while (!done[1] && c < 60000) begin
        pix_ready[1] = ($urandom_range(0, 99) < 70);
        wr_busy[1]   = ($urandom_range(0, 99) < 10);
        step();
        c++;
      end
    end
    wr_busy[1] = 1'b0;
    pix_ready[1] = 1'b1;
    check("rand_done", done[1], 1);
    step(2);
    frame_end(1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
